fifo_word_packer: RTL and testbench

- Read-side consumer of the async FIFO; runs entirely in the FIFO read domain.
- Drains DATA_WIDTH-bit entries through the FIFO's rd_en/rdata/empty/underflow interface.
- Packs PACK consecutive entries into one output word and presents it on a valid/ready stream.
- Supports a flush request that emits a partial word with a byte-keep mask.

---
 rtl/fifo_word_packer.sv | 173 +++++++++++++++++
 tb/tb_fifo_word_packer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// ============================================================================
//  Module   : fifo_word_packer
//  Purpose  : Read-side FIFO consumer. It packs PACK entries into one output
//             word on a valid/ready stream and supports a partial-word flush.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_word_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       rd_clk,
    input  logic                       rst,
    input  logic                       fifo_empty,
    input  logic [DATA_WIDTH-1:0]      fifo_rdata,
    input  logic                       fifo_underflow,
    output logic                       fifo_rd_en,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH*PACK-1:0] out_data,
    output logic [PACK-1:0]            out_keep,
    output logic                       out_last,
    output logic [CNT_WIDTH-1:0]       word_cnt,
    output logic                       err_underflow
);

    localparam int LCW = $clog2(PACK + 1);

    typedef enum logic [1:0] {
        ST_FILL       = 2'd0,
        ST_HOLD       = 2'd1,
        ST_FLUSH_WAIT = 2'd2
    } state_t;

    state_t                           state_q, state_d;
    logic [LCW-1:0]                   count_q, count_d;
    logic                             pending_q, pending_d;
    logic                             rd_en_q, rd_en_d;
    logic [PACK-1:0][DATA_WIDTH-1:0]  lanes_q, lanes_d;
    logic                             out_valid_q, out_valid_d;
    logic [DATA_WIDTH*PACK-1:0]       out_data_q, out_data_d;
    logic [PACK-1:0]                  out_keep_q, out_keep_d;
    logic                             out_last_q, out_last_d;
    logic [CNT_WIDTH-1:0]             word_cnt_q, word_cnt_d;
    logic                             err_q, err_d;

    logic [LCW-1:0]                   land_cnt;
    logic [PACK-1:0][DATA_WIDTH-1:0]  land_lanes;
    logic                             load;
    logic                             load_last;
    logic [LCW:0]                     inflight;

    always_comb begin
        land_cnt    = count_q;
        land_lanes  = lanes_q;
        err_d       = err_q;
        state_d     = state_q;
        pending_d   = rd_en_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        word_cnt_d  = word_cnt_q;
        load        = 1'b0;
        load_last   = 1'b0;

        // Data for last cycle's read lands now; an underflowed read adds no lane.
        if (pending_q) begin
            if (fifo_underflow) begin
                err_d = 1'b1;
            end else begin
                for (int i = 0; i < PACK; i++) begin
                    if (count_q == LCW'(i)) begin
                        land_lanes[i] = fifo_rdata;
                    end
                end
                land_cnt = count_q + LCW'(1);
            end
        end

        count_d = land_cnt;
        lanes_d = land_lanes;

        case (state_q)
            ST_FILL: begin
                if (land_cnt == LCW'(PACK)) begin
                    load = 1'b1;
                end else if (flush && ((count_q != '0) || pending_q)) begin
                    state_d = ST_FLUSH_WAIT;
                end
            end
            ST_FLUSH_WAIT: begin
                if (!rd_en_q) begin
                    if (land_cnt != '0) begin
                        load      = 1'b1;
                        load_last = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    word_cnt_d  = word_cnt_q + CNT_WIDTH'(1);
                    state_d     = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        if (load) begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
            out_last_d  = load_last;
            count_d     = '0;
            for (int i = 0; i < PACK; i++) begin
                out_keep_d[i] = (LCW'(i) < land_cnt);
                out_data_d[i*DATA_WIDTH +: DATA_WIDTH] =
                    (LCW'(i) < land_cnt) ? land_lanes[i] : '0;
            end
        end

        // Lanes already held plus the read issued this cycle must leave room.
        inflight = (LCW+1)'(count_d) + (LCW+1)'(rd_en_q);
        rd_en_d  = (state_d == ST_FILL) && !fifo_empty &&
                   (inflight < (LCW+1)'(PACK));
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            count_q     <= '0;
            pending_q   <= 1'b0;
            rd_en_q     <= 1'b0;
            lanes_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            word_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            rd_en_q     <= rd_en_d;
            lanes_q     <= lanes_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            word_cnt_q  <= word_cnt_d;
            err_q       <= err_d;
        end
    end

    assign fifo_rd_en    = rd_en_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_keep      = out_keep_q;
    assign out_last      = out_last_q;
    assign word_cnt      = word_cnt_q;
    assign err_underflow = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
// ============================================================================
//  Module   : tb_fifo_word_packer
//  Purpose  : Directed self-checking bench for fifo_word_packer with a
//             behavioural FIFO model driving the read interface.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_word_packer;

    localparam int DW  = 8;
    localparam int PK  = 4;
    // Narrow word counter so the wrap is reachable in a short run.
    localparam int CW  = 4;

    logic              rd_clk = 1'b0;
    logic              rst    = 1'b1;
    logic              fifo_empty;
    logic [DW-1:0]     fifo_rdata     = '0;
    logic              fifo_underflow = 1'b0;
    logic              fifo_rd_en;
    logic              flush     = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DW*PK-1:0]  out_data;
    logic [PK-1:0]     out_keep;
    logic              out_last;
    logic [CW-1:0]     word_cnt;
    logic              err_underflow;

    int passed = 0;
    int total  = 0;

    fifo_word_packer #(.DATA_WIDTH(DW), .PACK(PK), .CNT_WIDTH(CW)) dut (
        .rd_clk         (rd_clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_rdata     (fifo_rdata),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_keep       (out_keep),
        .out_last       (out_last),
        .word_cnt       (word_cnt),
        .err_underflow  (err_underflow)
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO model: registered read data, underflow when empty or when forced.
    logic [7:0] mem [0:255];
    int wr_ptr    = 0;
    int rd_ptr    = 0;
    int rd_seen   = 0;
    int uf_target = -1;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge rd_clk) begin
        fifo_underflow <= 1'b0;
        if (fifo_rd_en) begin
            rd_seen <= rd_seen + 1;
            if ((rd_seen + 1 == uf_target) || (rd_ptr == wr_ptr)) begin
                fifo_underflow <= 1'b1;
                fifo_rdata     <= 8'hEE;
            end else begin
                fifo_rdata <= mem[rd_ptr[7:0]];
                rd_ptr     <= rd_ptr + 1;
            end
        end
    end

    task automatic push(input logic [7:0] v);
        mem[wr_ptr[7:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_valid(input string tag);
        for (int n = 0; n < 40; n++) begin
            @(negedge rd_clk);
            if (out_valid) break;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_data"},  64'(out_data), 64'd0);
        check({tag, "_keep"},  64'(out_keep), 64'd0);
        check({tag, "_last"},  64'(out_last), 64'd0);
        check({tag, "_cnt"},   64'(word_cnt), 64'd0);
        check({tag, "_err"},   64'(err_underflow), 64'd0);
    endtask

    logic [7:0]       rd_pat;
    logic [7:0]       val_pat;
    logic [DW*PK-1:0] dat;
    logic [PK-1:0]    kp;
    logic             lst;
    int               bad;
    logic             seen;

    initial begin
        // Reset state
        repeat (2) @(negedge rd_clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge rd_clk);

        // Full word, streaming; first rd_en to out_valid is PACK+1 cycles
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        dat = '0; kp = '0; lst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge rd_clk);
            rd_pat[i]  = fifo_rd_en;
            val_pat[i] = out_valid;
            if (out_valid) begin
                dat = out_data; kp = out_keep; lst = out_last;
            end
        end
        check("t1_rd_pattern",    64'(rd_pat),  64'h0F);
        check("t1_valid_pattern", 64'(val_pat), 64'h20);
        check("t1_data", 64'(dat), 64'h44332211);
        check("t1_keep", 64'(kp),  64'hF);
        check("t1_last", 64'(lst), 64'd0);
        check("t1_cnt",  64'(word_cnt), 64'd1);

        // Backpressure: word held stable, no reads while holding
        out_ready = 1'b0;
        for (int v = 1; v <= 8; v++) push(8'(v));
        wait_valid("t2_w0");
        check("t2_w0_data", 64'(out_data), 64'h04030201);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge rd_clk);
            if (!out_valid || out_data !== 32'h04030201 || fifo_rd_en) bad++;
        end
        check("t2_hold_stable", 64'(bad), 64'd0);
        out_ready = 1'b1;
        wait_valid("t2_w1");
        check("t2_w1_data", 64'(out_data), 64'h08070605);
        check("t2_w1_keep", 64'(out_keep), 64'hF);
        @(negedge rd_clk);
        check("t2_cnt", 64'(word_cnt), 64'd3);
        check("t2_err", 64'(err_underflow), 64'd0);

        // Flush of a partial word, then a flush with nothing buffered
        push(8'hAA); push(8'hBB);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge rd_clk);
            seen = seen | out_valid;
        end
        check("t3_no_early_word", 64'(seen), 64'd0);
        flush = 1'b1;
        @(negedge rd_clk);
        flush = 1'b0;
        wait_valid("t3_flush");
        check("t3_data", 64'(out_data), 64'h0000BBAA);
        check("t3_keep", 64'(out_keep), 64'h3);
        check("t3_last", 64'(out_last), 64'd1);
        @(negedge rd_clk);
        check("t3_cnt", 64'(word_cnt), 64'd4);
        flush = 1'b1;
        @(negedge rd_clk);
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge rd_clk);
            seen = seen | out_valid;
        end
        check("t3_empty_flush", 64'(seen), 64'd0);

        rst = 1'b1;
        @(negedge rd_clk);
        check("t4_pre_err", 64'(err_underflow), 64'd0);
        rst = 1'b0;
        @(negedge rd_clk);

        // Underflow on the second read: that lane is skipped, error sticks
        uf_target = rd_seen + 2;
        push(8'h10); push(8'h30); push(8'h40); push(8'h50);
        wait_valid("t4");
        check("t4_data", 64'(out_data), 64'h50403010);
        check("t4_keep", 64'(out_keep), 64'hF);
        check("t4_err",  64'(err_underflow), 64'd1);
        repeat (4) @(negedge rd_clk);
        check("t4_err_sticky", 64'(err_underflow), 64'd1);
        check("t4_cnt", 64'(word_cnt), 64'd1);

        // Asynchronous reset mid-word (two lanes held, one read landing)
        push(8'hA1); push(8'hA2); push(8'hA3);
        repeat (4) @(posedge rd_clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("t5_async");
        @(negedge rd_clk);
        rst = 1'b0;
        @(negedge rd_clk);
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        wait_valid("t5_clean");
        check("t5_data", 64'(out_data), 64'hC4C3C2C1);
        check("t5_keep", 64'(out_keep), 64'hF);
        check("t5_last", 64'(out_last), 64'd0);

        // Word counter wrap: 2^CW + 1 words after reset
        rst = 1'b1;
        @(negedge rd_clk);
        rst = 1'b0;
        @(negedge rd_clk);
        for (int v = 1; v <= 4 * ((1 << CW) + 1); v++) push(8'(v));
        for (int k = 0; k < (1 << CW) + 1; k++) begin
            wait_valid("t6_word");
            check("t6_data", 64'(out_data),
                  64'({8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)}));
        end
        @(negedge rd_clk);
        check("t6_wrap", 64'(word_cnt), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
